// File: rtl/storage_stack_param.sv
// Pointer-addressed LIFO stack with zero-latency TOS/NOS read ports and sticky
// overflow/underflow flags. Only one storage word is written per cycle.
module storage_stack_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           data_out,
    output logic [WIDTH-1:0]           nos_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt;
    logic             ovf_r;
    logic             unf_r;
    logic             ovf_set;
    logic             unf_set;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    tos_addr;
    logic [AW-1:0]    nos_addr;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_r == '0);
    assign is_full  = (count_r == DEPTH_C);
    assign tos_addr = AW'(count_r - ONE_C);
    assign nos_addr = AW'(count_r - TWO_C);

    // Operation decode: {push,pop} selects IDLE / PUSH / POP / REPLACE
    always_comb begin
        count_nxt = count_r;
        wr_en     = 1'b0;
        wr_addr   = '0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = count_r[AW-1:0];
                    count_nxt = count_r + ONE_C;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    count_nxt = count_r - ONE_C;
                end
            end
            2'b11: begin
                // Replacing on an empty stack degenerates into a plain push
                wr_en = 1'b1;
                if (is_empty) begin
                    wr_addr   = '0;
                    count_nxt = ONE_C;
                end else begin
                    wr_addr = tos_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt;
            ovf_r   <= ovf_set | (ovf_r & ~err_clr);
            unf_r   <= unf_set | (unf_r & ~err_clr);
        end
    end

    // Storage is never cleared; words above count are masked at the outputs
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem[wr_addr] <= data_in;
        end
    end

    assign data_out = is_empty ? '0 : mem[tos_addr];
    assign nos_out  = (count_r < TWO_C) ? '0 : mem[nos_addr];
    assign count    = count_r;
    assign empty    = is_empty;
    assign full     = is_full;
    assign ovf      = ovf_r;
    assign unf      = unf_r;

endmodule

// File: tb/tb_storage_stack_param.sv
// Bench for storage_stack_param: directed vector table, multi-cycle corner
// sequences, and a randomized run against a queue-based LIFO model.
module tb_storage_stack_param;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] nos_out;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    int tests  = 0;
    int failed = 0;

    storage_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .err_clr  (err_clr),
        .data_out (data_out),
        .nos_out  (nos_out),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .unf      (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: a queue whose back is the top of stack
    logic [WIDTH-1:0] mq[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    function automatic void model_step(bit p, bit q, bit c, logic [WIDTH-1:0] d);
        bit o = 1'b0;
        bit u = 1'b0;
        if (p && q) begin
            if (mq.size() == 0) mq.push_back(d);
            else mq[mq.size()-1] = d;
        end else if (p) begin
            if (mq.size() == DEPTH) o = 1'b1;
            else mq.push_back(d);
        end else if (q) begin
            if (mq.size() == 0) u = 1'b1;
            else void'(mq.pop_back());
        end
        m_ovf = o | (m_ovf & !c);
        m_unf = u | (m_unf & !c);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic [WIDTH-1:0] e_out, logic [WIDTH-1:0] e_nos,
                             logic [AW:0] e_cnt, logic e_ovf, logic e_unf);
        chk({tag, ".data_out"}, 32'(data_out), 32'(e_out));
        chk({tag, ".nos_out"},  32'(nos_out),  32'(e_nos));
        chk({tag, ".count"},    32'(count),    32'(e_cnt));
        chk({tag, ".empty"},    32'(empty),    32'(e_cnt == '0));
        chk({tag, ".full"},     32'(full),     32'(e_cnt == (AW+1)'(DEPTH)));
        chk({tag, ".ovf"},      32'(ovf),      32'(e_ovf));
        chk({tag, ".unf"},      32'(unf),      32'(e_unf));
    endtask

    task automatic check_model(string tag);
        logic [WIDTH-1:0] e_out;
        logic [WIDTH-1:0] e_nos;
        int n;
        n = mq.size();
        e_out = (n >= 1) ? mq[n-1] : '0;
        e_nos = (n >= 2) ? mq[n-2] : '0;
        check_all(tag, e_out, e_nos, (AW+1)'(n), m_ovf, m_unf);
    endtask

    task automatic step(bit p, bit q, bit c, logic [WIDTH-1:0] d);
        @(negedge clk);
        push = p; pop = q; err_clr = c; data_in = d;
        @(posedge clk);
        model_step(p, q, c, d);
        #1;
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
        #2 rst_n = 1'b0;
        #1 check_all(tag, '0, '0, '0, 1'b0, 1'b0);
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic             p;
        logic             q;
        logic             c;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] e_out;
        logic [WIDTH-1:0] e_nos;
        logic [AW:0]      e_cnt;
        logic             e_ovf;
        logic             e_unf;
    } vec_t;

    vec_t vecs[16];

    task automatic setv(int i, logic p, logic q, logic c, logic [WIDTH-1:0] din,
                        logic [WIDTH-1:0] e_out, logic [WIDTH-1:0] e_nos,
                        logic [AW:0] e_cnt, logic e_ovf, logic e_unf);
        vecs[i].p = p; vecs[i].q = q; vecs[i].c = c; vecs[i].din = din;
        vecs[i].e_out = e_out; vecs[i].e_nos = e_nos; vecs[i].e_cnt = e_cnt;
        vecs[i].e_ovf = e_ovf; vecs[i].e_unf = e_unf;
    endtask

    initial begin
        //      idx push  pop   clr   din       out       nos       cnt    ovf   unf
        setv(0,  1'b1, 1'b0, 1'b0, 16'h000A, 16'h000A, 16'h0000, 5'd1, 1'b0, 1'b0);
        setv(1,  1'b1, 1'b0, 1'b0, 16'h000B, 16'h000B, 16'h000A, 5'd2, 1'b0, 1'b0);
        setv(2,  1'b1, 1'b0, 1'b0, 16'h000C, 16'h000C, 16'h000B, 5'd3, 1'b0, 1'b0);
        setv(3,  1'b0, 1'b1, 1'b0, 16'h0000, 16'h000B, 16'h000A, 5'd2, 1'b0, 1'b0);
        setv(4,  1'b0, 1'b1, 1'b0, 16'h0000, 16'h000A, 16'h0000, 5'd1, 1'b0, 1'b0);
        setv(5,  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0);
        setv(6,  1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1);
        setv(7,  1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1);
        setv(8,  1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0);
        setv(9,  1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0000, 5'd1, 1'b0, 1'b0);
        setv(10, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 16'h0001, 5'd2, 1'b0, 1'b0);
        setv(11, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0009, 16'h0001, 5'd2, 1'b0, 1'b0);
        setv(12, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h0000, 5'd1, 1'b0, 1'b0);
        setv(13, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0);
        setv(14, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 5'd1, 1'b0, 1'b0);
        setv(15, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0);

        do_reset("reset0");
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].p, vecs[i].q, vecs[i].c, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_nos,
                      vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill, overflow, then drain in reverse order
        do_reset("reset1");
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b0, 1'b0, WIDTH'(k));
        check_all("filled", WIDTH'(DEPTH), WIDTH'(DEPTH-1), (AW+1)'(DEPTH), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h00FF);
        check_all("ovf_push", WIDTH'(DEPTH), WIDTH'(DEPTH-1), (AW+1)'(DEPTH), 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h00FE);
        check_all("ovf_setwins", WIDTH'(DEPTH), WIDTH'(DEPTH-1), (AW+1)'(DEPTH), 1'b1, 1'b0);
        for (int k = DEPTH; k >= 1; k--) begin
            chk($sformatf("lifo%0d", k), 32'(data_out), 32'(k));
            step(1'b0, 1'b1, 1'b0, '0);
        end
        check_all("drained", '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, '0);
        check_all("ovf_clr", '0, '0, '0, 1'b0, 1'b0);

        // Replace on a full stack
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b0, 1'b0, WIDTH'(k));
        step(1'b1, 1'b1, 1'b0, 16'h0007);
        check_all("full_replace", 16'h0007, WIDTH'(DEPTH-1), (AW+1)'(DEPTH), 1'b0, 1'b0);

        // Asynchronous reset between edges, then normal operation
        do_reset("reset2");
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 16'h0011);
        step(1'b1, 1'b0, 1'b0, 16'h0022);
        step(1'b1, 1'b0, 1'b0, 16'h0033);
        check_all("pre_async", 16'h0033, 16'h0022, 5'd3, 1'b0, 1'b1);
        do_reset("async_rst");
        step(1'b1, 1'b0, 1'b0, 16'h0004);
        check_all("post_rst", 16'h0004, 16'h0000, 5'd1, 1'b0, 1'b0);

        // Randomized run with phases biased toward fill, drain and mixed traffic
        do_reset("reset3");
        for (int i = 0; i < 3000; i++) begin
            int phase;
            int pp;
            int qp;
            bit p;
            bit q;
            bit c;
            phase = (i / 300) % 3;
            pp = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
            qp = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
            p = ($urandom_range(99) < pp);
            q = ($urandom_range(99) < qp);
            c = ($urandom_range(99) < 10);
            step(p, q, c, WIDTH'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
